// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encoding, the HID keycodes
// the controller reacts to, and the default timer-second divisor.
package game_pkg;

  // Values are visible on state_dbg, so the encoding is fixed.
  typedef enum logic [3:0] {
    StMenu  = 4'd0,
    StLoad  = 4'd1,
    StPlay  = 4'd2,
    StClear = 4'd3,
    StLose  = 4'd4,
    StOver  = 4'd5,
    StWin   = 4'd6
  } game_state_e;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;

  localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

endpackage

// File: rtl/level_timer.sv
// Per-level countdown: a clk-cycle divider producing one-second ticks and an 8-bit
// seconds counter that decrements on each tick and saturates at zero.
//   clk, reset    : clock, synchronous active-high reset
//   load          : clear the divider and load load_val into the counter
//   run           : advance the divider (only while the level is being played)
//   load_val      : value loaded by load
//   time_left     : remaining seconds
//   expire_pulse  : high in the cycle where the divider wraps while time_left == 1
module level_timer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic [7:0] load_val,
  output logic [7:0] time_left,
  output logic       expire_pulse
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      time_q, time_d;
  logic            wrap;

  assign wrap         = run && (div_q == DivMax);
  assign expire_pulse = wrap && (time_q == 8'd1);
  assign time_left    = time_q;

  always_comb begin
    div_d  = div_q;
    time_d = time_q;
    if (load) begin
      div_d  = '0;
      time_d = load_val;
    end else if (run) begin
      div_d = wrap ? '0 : div_q + DivW'(1);
      if (wrap && (time_q != 8'd0)) begin
        time_d = time_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      time_q <= 8'd0;
    end else begin
      div_q  <= div_d;
      time_q <= time_d;
    end
  end

endmodule

// File: rtl/game_level_sequencer.sv
// Game-flow controller: menu -> load -> play -> clear/lose -> next level/game over/win.
// Owns the lives counter and the level countdown; turns keycodes and the push-button
// into single-cycle events.
//   clk, reset           : clock, synchronous active-high reset
//   keycode              : current HID keycode (0x00 = none)
//   button_press         : synchronized push-button level
//   level_done/player_hit: gameplay reports, honoured only in PLAY
//   level, lives, time_left : HUD values
//   menu_sig, play_en, level_start, game_over, game_won, state_dbg : state decodes
module game_level_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS = 3,
  parameter int unsigned LEVEL_TIME = 60,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode,
  input  logic       button_press,
  input  logic       level_done,
  input  logic       player_hit,
  output logic [2:0] level,
  output logic       menu_sig,
  output logic       play_en,
  output logic       level_start,
  output logic [7:0] time_left,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       game_won,
  output logic [3:0] state_dbg
);

  game_state_e state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  prev_key_q;
  logic        prev_btn_q;

  logic        enter_evt, esc_evt, btn_evt, cont_evt;
  logic        timer_load, timer_expire;
  logic [7:0]  timer_val;

  assign enter_evt = (keycode == KEY_ENTER) && (prev_key_q != KEY_ENTER);
  assign esc_evt   = (keycode == KEY_ESC) && (prev_key_q != KEY_ESC);
  assign btn_evt   = button_press && !prev_btn_q;
  assign cont_evt  = enter_evt || btn_evt;

  level_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_level_timer (
    .clk          (clk),
    .reset        (reset),
    .load         (timer_load),
    .run          (state_q == StPlay),
    .load_val     (timer_val),
    .time_left    (time_left),
    .expire_pulse (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    lives_d    = lives_q;
    timer_load = 1'b0;
    timer_val  = 8'(LEVEL_TIME);
    unique case (state_q)
      StMenu: begin
        if (enter_evt) begin
          state_d = StLoad;
          level_d = 3'd1;
          lives_d = 2'(LIVES);
        end
      end
      StLoad: begin
        timer_load = 1'b1;
        state_d    = StPlay;
      end
      StPlay: begin
        // Priority: quit, then objective, then death/timeout.
        if (esc_evt) begin
          state_d = StMenu;
          level_d = 3'd0;
          lives_d = 2'(LIVES);
        end else if (level_done) begin
          state_d = (level_q == 3'(NUM_LEVELS)) ? StWin : StClear;
        end else if (player_hit || timer_expire) begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? StOver : StLose;
        end
      end
      StClear: begin
        if (cont_evt) begin
          state_d = StLoad;
          level_d = level_q + 3'd1;
        end
      end
      StLose: begin
        if (cont_evt) begin
          state_d = StLoad;
        end
      end
      StOver, StWin: begin
        if (cont_evt) begin
          state_d    = StMenu;
          level_d    = 3'd0;
          lives_d    = 2'(LIVES);
          timer_load = 1'b1;
          timer_val  = 8'd0;
        end
      end
      default: begin
        state_d = StMenu;
        level_d = 3'd0;
        lives_d = 2'(LIVES);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StMenu;
      level_q    <= 3'd0;
      lives_q    <= 2'(LIVES);
      prev_key_q <= 8'h00;
      prev_btn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      lives_q    <= lives_d;
      prev_key_q <= keycode;
      prev_btn_q <= button_press;
    end
  end

  assign level       = level_q;
  assign lives       = lives_q;
  assign state_dbg   = state_q;
  assign menu_sig    = (state_q == StMenu);
  assign play_en     = (state_q == StPlay);
  assign level_start = (state_q == StLoad);
  assign game_over   = (state_q == StOver);
  assign game_won    = (state_q == StWin);

endmodule

// File: tb/tb_game_level_sequencer.sv
module tb_game_level_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned LT = 3;
  localparam int unsigned NL = 2;
  localparam int unsigned LV = 2;

  localparam int M_MENU = 0, M_LOAD = 1, M_PLAY = 2, M_CLEAR = 3;
  localparam int M_LOSE = 4, M_OVER = 5, M_WIN = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keycode;
  logic       button_press, level_done, player_hit;
  logic [2:0] level;
  logic       menu_sig, play_en, level_start, game_over, game_won;
  logic [7:0] time_left;
  logic [1:0] lives;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  game_level_sequencer #(
    .NUM_LEVELS (NL),
    .LEVEL_TIME (LT),
    .LIVES      (LV),
    .TICK_DIV   (TD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keycode      (keycode),
    .button_press (button_press),
    .level_done   (level_done),
    .player_hit   (player_hit),
    .level        (level),
    .menu_sig     (menu_sig),
    .play_en      (play_en),
    .level_start  (level_start),
    .time_left    (time_left),
    .lives        (lives),
    .game_over    (game_over),
    .game_won     (game_won),
    .state_dbg    (state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] lvl;
    logic       menu;
    logic       play;
    logic       start;
    logic [7:0] tl;
    logic [1:0] lv;
    logic       over;
    logic       won;
  } obs_t;

  obs_t exp_q[$];
  obs_t e_obs, a_obs;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: game mode, HUD values, and PLAY cycles elapsed since level load.
  int         m_mode, m_level, m_lives, m_time, m_pc;
  logic [7:0] m_prev_key;
  logic       m_prev_btn;

  logic [7:0] cur_key;
  logic       cur_btn;
  logic       rnd_rst;

  task automatic model_step(input logic rst, input logic [7:0] key, input logic btn,
                            input logic done, input logic hit);
    logic enter, esc, bev, cont, timeout;
    if (rst) begin
      m_mode = M_MENU; m_level = 0; m_lives = LV; m_time = 0; m_pc = 0;
      m_prev_key = 8'h00; m_prev_btn = 1'b0;
      return;
    end
    enter = (key == 8'h28) && (m_prev_key != 8'h28);
    esc   = (key == 8'h29) && (m_prev_key != 8'h29);
    bev   = btn && !m_prev_btn;
    cont  = enter || bev;
    case (m_mode)
      M_MENU: if (enter) begin m_mode = M_LOAD; m_level = 1; m_lives = LV; end
      M_LOAD: begin m_time = LT; m_pc = 0; m_mode = M_PLAY; end
      M_PLAY: begin
        // One second passes every TD cycles of play; time shown saturates at zero.
        timeout = (((m_pc + 1) % TD) == 0) && (m_time == 1);
        m_pc++;
        m_time = (m_pc / TD >= LT) ? 0 : LT - m_pc / TD;
        if (esc) begin
          m_mode = M_MENU; m_level = 0; m_lives = LV;
        end else if (done) begin
          m_mode = (m_level == NL) ? M_WIN : M_CLEAR;
        end else if (hit || timeout) begin
          m_mode  = (m_lives == 1) ? M_OVER : M_LOSE;
          m_lives = m_lives - 1;
        end
      end
      M_CLEAR: if (cont) begin m_mode = M_LOAD; m_level++; end
      M_LOSE:  if (cont) m_mode = M_LOAD;
      default: if (cont) begin m_mode = M_MENU; m_level = 0; m_lives = LV; m_time = 0; end
    endcase
    m_prev_key = key;
    m_prev_btn = btn;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.st    = 4'(m_mode);
    o.lvl   = 3'(m_level);
    o.menu  = (m_mode == M_MENU);
    o.play  = (m_mode == M_PLAY);
    o.start = (m_mode == M_LOAD);
    o.tl    = 8'(m_time);
    o.lv    = 2'(m_lives);
    o.over  = (m_mode == M_OVER);
    o.won   = (m_mode == M_WIN);
    return o;
  endfunction

  // Applies one cycle of stimulus; expected post-edge outputs go to the scoreboard.
  task automatic drive(input logic rst, input logic done, input logic hit);
    reset        = rst;
    keycode      = cur_key;
    button_press = cur_btn;
    level_done   = done;
    player_hit   = hit;
    model_step(rst, cur_key, cur_btn, done, hit);
    exp_q.push_back(model_obs());
    @(negedge clk);
  endtask

  task automatic press_key(input logic [7:0] k);
    cur_key = k;
    drive(1'b0, 1'b0, 1'b0);
    cur_key = 8'h00;
  endtask

  task automatic press_btn();
    cur_btn = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    cur_btn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a new output set.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      e_obs = exp_q.pop_front();
      a_obs = {state_dbg, level, menu_sig, play_en, level_start, time_left, lives,
               game_over, game_won};
      n_checks++;
      if (a_obs === e_obs) begin
        n_pass++;
      end else begin
        $display("FAIL outputs cycle %0d: got st=%0d lvl=%0d tl=%0d lives=%0d mpsow=%b%b%b%b%b, required st=%0d lvl=%0d tl=%0d lives=%0d mpsow=%b%b%b%b%b",
                 cyc, a_obs.st, a_obs.lvl, a_obs.tl, a_obs.lv, a_obs.menu, a_obs.play,
                 a_obs.start, a_obs.over, a_obs.won, e_obs.st, e_obs.lvl, e_obs.tl,
                 e_obs.lv, e_obs.menu, e_obs.play, e_obs.start, e_obs.over, e_obs.won);
      end
    end
  end

  initial begin
    cur_key = 8'h00;
    cur_btn = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 1'b0);

    // Enter held 10 cycles: one LOAD, then PLAY, no re-trigger.
    idle(1);
    cur_key = 8'h28;
    idle(10);
    cur_key = 8'h00;
    // Let the countdown expire into LOSE, then continue by button.
    idle(8);
    press_btn();
    idle(3);
    // Death with one life left -> OVER, then back to MENU.
    drive(1'b0, 1'b0, 1'b1);
    idle(2);
    press_key(8'h28);
    idle(1);
    // Clear level 1, load level 2, clear it -> WIN, then MENU.
    press_key(8'h28);
    idle(2);
    drive(1'b0, 1'b1, 1'b0);
    press_key(8'h28);
    idle(2);
    drive(1'b0, 1'b1, 1'b0);
    idle(1);
    press_btn();
    idle(1);
    // level_done + player_hit on the expiring tick -> CLEAR with lives kept.
    press_key(8'h28);
    idle(12);
    drive(1'b0, 1'b1, 1'b1);
    idle(1);
    // ESC from PLAY, then reset mid-PLAY.
    press_key(8'h28);
    idle(2);
    press_key(8'h29);
    idle(1);
    press_key(8'h28);
    idle(4);
    drive(1'b1, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0: cur_key = 8'h00;
          1: cur_key = 8'h28;
          2: cur_key = 8'h29;
          default: cur_key = 8'h04;
        endcase
      end
      if ($urandom_range(3) == 0) cur_btn = ~cur_btn;
      rnd_rst = ($urandom_range(499) == 0);
      if (rnd_rst) begin
        cur_key = 8'h00;
        cur_btn = 1'b0;
      end
      drive(rnd_rst, $urandom_range(29) == 0, $urandom_range(19) == 0);
    end

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
